// File: rtl/ahb2wb_bridge.sv
// AHB-Lite slave to Wishbone classic master bridge with byte-lane selects,
// alignment checking and two-cycle ERROR response. Optional bus-hang timeout: AHB2WB_TIMEOUT_EN.
module ahb2wb_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    HCLK,
   input  logic                    HRESET,
   input  logic                    HSEL,
   input  logic [ADDR_WIDTH-1:0]   HADDR,
   input  logic [1:0]              HTRANS,
   input  logic                    HWRITE,
   input  logic [2:0]              HSIZE,
   input  logic [2:0]              HBURST,
   input  logic [3:0]              HPROT,
   input  logic [DATA_WIDTH-1:0]   HWDATA,
   input  logic                    HREADY,
   output logic                    HREADYOUT,
   output logic [DATA_WIDTH-1:0]   HRDATA,
   output logic                    HRESP,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   output logic                    wb_we_o,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i,
   output logic [1:0]              o_dbg_state
);

   localparam int SEL_W  = DATA_WIDTH / 8;
   localparam int LANE_W = $clog2(SEL_W);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WB   = 2'd1;
   localparam logic [1:0] S_ERR1 = 2'd2;
   localparam logic [1:0] S_ERR2 = 2'd3;

   logic [1:0]            r_state;
   logic [1:0]            w_next;
   logic [ADDR_WIDTH-1:0] r_adr;
   logic [SEL_W-1:0]      r_sel;
   logic                  r_we;

   logic                  w_in_wb;
   logic                  w_slot;
   logic                  w_sample;
   logic                  w_size_bad;
   logic                  w_misalign;
   logic                  w_legal;
   logic                  w_timeout;
   logic [LANE_W-1:0]     w_lane_ones;
   logic [LANE_W-1:0]     w_low_mask;
   logic [SEL_W-1:0]      w_bytes;
   logic [SEL_W-1:0]      w_sel;
   logic                  w_unused;

   assign w_in_wb = (r_state == S_WB);

   // Handshake: an AHB address phase is taken when HSEL && HREADY && HTRANS[1];
   // the Wishbone side completes a strobe cycle on wb_ack_i or wb_err_i (err wins),
   // and HREADYOUT only rises in WB on a clean ack.
   assign w_slot   = (r_state == S_IDLE) || (r_state == S_ERR2) ||
                     (w_in_wb && wb_ack_i && !wb_err_i);
   assign w_sample = HSEL && HREADY && HTRANS[1] && w_slot;

   assign w_size_bad  = (HSIZE > 3'(LANE_W));
   assign w_lane_ones = '1;
   assign w_low_mask  = ~(w_lane_ones << HSIZE);
   assign w_misalign  = |(HADDR[LANE_W-1:0] & w_low_mask);
   assign w_legal     = !w_size_bad && !w_misalign;

   always_comb begin
      w_bytes = '0;
      case (HSIZE)
         3'd0:    w_bytes = SEL_W'(1);
         3'd1:    w_bytes = SEL_W'(3);
         3'd2:    w_bytes = SEL_W'(15);
         default: w_bytes = '1;
      endcase
   end

   assign w_sel = w_bytes << HADDR[LANE_W-1:0];

`ifdef AHB2WB_TIMEOUT_EN
   logic [15:0] r_tcnt;

   // Counts strobe cycles that saw neither ack nor err; the last allowed one aborts.
   assign w_timeout = w_in_wb && !wb_ack_i && !wb_err_i &&
                      (r_tcnt == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_tcnt <= '0;
      end else if (w_sample && w_legal) begin
         r_tcnt <= '0;
      end else if (w_in_wb && !wb_ack_i && !wb_err_i) begin
         r_tcnt <= r_tcnt + 16'd1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_ERR2: begin
            if (w_sample) begin
               w_next = w_legal ? S_WB : S_ERR1;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_WB: begin
            if (wb_err_i) begin
               w_next = S_ERR1;
            end else if (wb_ack_i) begin
               if (w_sample) begin
                  w_next = w_legal ? S_WB : S_ERR1;
               end else begin
                  w_next = S_IDLE;
               end
            end else if (w_timeout) begin
               w_next = S_ERR1;
            end else begin
               w_next = S_WB;
            end
         end
         S_ERR1:  w_next = S_ERR2;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_adr <= '0;
         r_sel <= '0;
         r_we  <= 1'b0;
      end else if (w_sample && w_legal) begin
         r_adr <= HADDR;
         r_sel <= w_sel;
         r_we  <= HWRITE;
      end
   end

   assign wb_cyc_o = w_in_wb;
   assign wb_stb_o = w_in_wb;
   assign wb_adr_o = w_in_wb ? r_adr : '0;
   assign wb_sel_o = w_in_wb ? r_sel : '0;
   assign wb_we_o  = w_in_wb && r_we;
   assign wb_dat_o = HWDATA;
   assign HRDATA   = wb_dat_i;

   always_comb begin
      HREADYOUT = 1'b1;
      case (r_state)
         S_IDLE:  HREADYOUT = 1'b1;
         S_WB:    HREADYOUT = wb_ack_i && !wb_err_i;
         S_ERR1:  HREADYOUT = 1'b0;
         default: HREADYOUT = 1'b1;
      endcase
   end

   assign HRESP       = (r_state == S_ERR1) || (r_state == S_ERR2);
   assign o_dbg_state = r_state;

   assign w_unused = &{1'b0, HBURST, HPROT, HTRANS[0]};

endmodule

// File: tb/tb_ahb2wb_bridge.sv
// Self-checking bench for ahb2wb_bridge (DATA_WIDTH=32); the timeout scenario
// runs only when AHB2WB_TIMEOUT_EN is defined.
module tb_ahb2wb_bridge;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int EXP_W = 32 + 4 + 1 + 32;

   logic          HCLK;
   logic          HRESET;
   logic          HSEL;
   logic [AW-1:0] HADDR;
   logic [1:0]    HTRANS;
   logic          HWRITE;
   logic [2:0]    HSIZE;
   logic [2:0]    HBURST;
   logic [3:0]    HPROT;
   logic [DW-1:0] HWDATA;
   logic          HREADY;
   logic          HREADYOUT;
   logic [DW-1:0] HRDATA;
   logic          HRESP;
   logic [AW-1:0] wb_adr_o;
   logic [DW-1:0] wb_dat_o;
   logic [3:0]    wb_sel_o;
   logic          wb_we_o;
   logic          wb_cyc_o;
   logic          wb_stb_o;
   logic [DW-1:0] wb_dat_i;
   logic          wb_ack_i;
   logic          wb_err_i;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;

   logic [EXP_W-1:0] exp_q[$];

   int   ack_delay = 0;
   logic err_mode  = 1'b0;
   logic never_ack = 1'b0;

   ahb2wb_bridge #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .HSEL       (HSEL),
      .HADDR      (HADDR),
      .HTRANS     (HTRANS),
      .HWRITE     (HWRITE),
      .HSIZE      (HSIZE),
      .HBURST     (HBURST),
      .HPROT      (HPROT),
      .HWDATA     (HWDATA),
      .HREADY     (HREADY),
      .HREADYOUT  (HREADYOUT),
      .HRDATA     (HRDATA),
      .HRESP      (HRESP),
      .wb_adr_o   (wb_adr_o),
      .wb_dat_o   (wb_dat_o),
      .wb_sel_o   (wb_sel_o),
      .wb_we_o    (wb_we_o),
      .wb_cyc_o   (wb_cyc_o),
      .wb_stb_o   (wb_stb_o),
      .wb_dat_i   (wb_dat_i),
      .wb_ack_i   (wb_ack_i),
      .wb_err_i   (wb_err_i),
      .o_dbg_state(dbg_state)
   );

   // Single slave on the fabric: HREADY follows the slave's own ready.
   assign HREADY = HREADYOUT;

   // Clock / reset
   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   function automatic logic [3:0] exp_sel(input logic [31:0] addr, input logic [2:0] size);
      case (size)
         3'd0:    exp_sel = 4'b0001 << addr[1:0];
         3'd1:    exp_sel = addr[1] ? 4'b1100 : 4'b0011;
         default: exp_sel = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] rd_pattern(input logic [31:0] addr);
      rd_pattern = 32'hC0DE_0000 | {16'h0, addr[15:0]};
   endfunction

   // Wishbone peripheral model: acks (or errs) after ack_delay extra strobe cycles.
   initial begin
      int   cnt;
      logic was_active;
      logic active;
      logic fire;
      cnt        = 0;
      was_active = 1'b0;
      wb_ack_i   = 1'b0;
      wb_err_i   = 1'b0;
      wb_dat_i   = '0;
      forever begin
         @(posedge HCLK);
         #1;
         active = wb_cyc_o && wb_stb_o;
         if (active) begin
            if (!was_active || wb_ack_i || wb_err_i) cnt = 0;
            else cnt++;
         end else begin
            cnt = 0;
         end
         was_active = active;
         fire       = active && !never_ack && (cnt == ack_delay);
         wb_ack_i   = fire;
         wb_err_i   = fire && err_mode;
         wb_dat_i   = active ? rd_pattern(wb_adr_o) : '0;
      end
   end

   // Scoreboard: pop one expected Wishbone request per completed strobe cycle.
   always @(negedge HCLK) begin
      logic [EXP_W-1:0] e;
      if (!HRESET && wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i)) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("wb_adr", wb_adr_o, e[68:37]);
            check("wb_sel", wb_sel_o, e[36:33]);
            check("wb_we",  wb_we_o,  e[32]);
            if (e[32]) check("wb_dat", wb_dat_o, e[31:0]);
         end
      end
   end

   task automatic push_exp(input logic [31:0] addr, input logic [2:0] size,
                           input logic wr, input logic [31:0] wdata);
      exp_q.push_back({addr, exp_sel(addr, size), wr, wdata});
   endtask

   task automatic drive_idle();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HADDR  = '0;
      HWRITE = 1'b0;
      HSIZE  = 3'd0;
   endtask

   // Driver: one AHB transfer; called at posedge+1, returns at posedge+1.
   task automatic ahb_single(input logic [31:0] addr, input logic [2:0] size, input logic wr,
                             input logic [31:0] wdata, input logic legal, input logic exp_err,
                             input int exp_waits, input string tag);
      int   waits;
      logic err1_seen;
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HADDR  = addr;
      HWRITE = wr;
      HSIZE  = size;
      @(negedge HCLK);
      check({tag, "_addr_rdy"}, HREADYOUT, 1);
      if (legal) push_exp(addr, size, wr, wdata);
      @(posedge HCLK);
      #1;
      drive_idle();
      HWDATA = wdata;
      @(negedge HCLK);
      check({tag, "_cyc"}, wb_cyc_o, legal);
      waits     = 0;
      err1_seen = 1'b0;
      while (!HREADYOUT && waits <= 40) begin
         err1_seen = HRESP;
         waits++;
         @(negedge HCLK);
      end
      check({tag, "_waits"}, waits, exp_waits);
      check({tag, "_resp"}, HRESP, exp_err);
      if (exp_err) check({tag, "_err1"}, err1_seen, 1);
      else if (!wr) check({tag, "_rdata"}, HRDATA, rd_pattern(addr));
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      HRESET = 1'b1;
      HBURST = 3'd0;
      HPROT  = 4'd0;
      HWDATA = '0;
      drive_idle();

      @(negedge HCLK);
      check("rst_rdy",  HREADYOUT, 1);
      check("rst_resp", HRESP, 0);
      check("rst_cyc",  wb_cyc_o, 0);
      check("rst_stb",  wb_stb_o, 0);
      check("rst_we",   wb_we_o, 0);
      check("rst_adr",  wb_adr_o, 0);
      check("rst_sel",  wb_sel_o, 0);
      check("rst_state", dbg_state, 0);
      HRESET = 1'b0;
      @(posedge HCLK);
      #1;

      // BUSY: zero-wait OKAY, no Wishbone cycle
      HSEL   = 1'b1;
      HTRANS = 2'b01;
      HADDR  = 32'h100;
      @(negedge HCLK);
      check("busy_rdy",  HREADYOUT, 1);
      check("busy_resp", HRESP, 0);
      @(posedge HCLK);
      #1;
      drive_idle();
      @(negedge HCLK);
      check("busy_cyc", wb_cyc_o, 0);
      @(posedge HCLK);
      #1;

      // Word write, ack in the second strobe cycle
      ack_delay = 1;
      ahb_single(32'h100, 3'd2, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1, "wr_word");
      check("idle_adr", wb_adr_o, 0);
      ack_delay = 0;
      ahb_single(32'h7,   3'd0, 1'b1, 32'h5A000000, 1'b1, 1'b0, 0, "wr_byte");
      ahb_single(32'h10A, 3'd1, 1'b1, 32'h12340000, 1'b1, 1'b0, 0, "wr_half");

      // Back-to-back byte read @0x103 and halfword read @0x102, 0-wait acks
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HADDR  = 32'h103;
      HWRITE = 1'b0;
      HSIZE  = 3'd0;
      push_exp(32'h103, 3'd0, 1'b0, 32'h0);
      @(negedge HCLK);
      check("b2b_a1_rdy", HREADYOUT, 1);
      @(posedge HCLK);
      #1;
      HADDR = 32'h102;
      HSIZE = 3'd1;
      push_exp(32'h102, 3'd1, 1'b0, 32'h0);
      @(negedge HCLK);
      check("b2b_d1_cyc",   wb_cyc_o, 1);
      check("b2b_d1_rdy",   HREADYOUT, 1);
      check("b2b_d1_resp",  HRESP, 0);
      check("b2b_d1_rdata", HRDATA, 32'hC0DE_0103);
      @(posedge HCLK);
      #1;
      drive_idle();
      @(negedge HCLK);
      check("b2b_d2_cyc",   wb_cyc_o, 1);
      check("b2b_d2_rdy",   HREADYOUT, 1);
      check("b2b_d2_rdata", HRDATA, 32'hC0DE_0102);
      @(posedge HCLK);
      #1;
      @(negedge HCLK);
      check("b2b_end_cyc", wb_cyc_o, 0);
      @(posedge HCLK);
      #1;

      // Illegal transfers: misaligned halfword, oversize
      ahb_single(32'h101, 3'd1, 1'b0, 32'h0, 1'b0, 1'b1, 1, "misalign");
      ahb_single(32'h100, 3'd3, 1'b0, 32'h0, 1'b0, 1'b1, 1, "oversize");

      // err and ack together in the first strobe cycle: err wins
      err_mode = 1'b1;
      ahb_single(32'h200, 3'd2, 1'b0, 32'h0, 1'b1, 1'b1, 2, "err_ack");
      err_mode = 1'b0;
      ahb_single(32'h204, 3'd2, 1'b0, 32'h0, 1'b1, 1'b0, 0, "after_err");

`ifdef AHB2WB_TIMEOUT_EN
      never_ack = 1'b1;
      ahb_single(32'h300, 3'd2, 1'b0, 32'h0, 1'b1, 1'b1, 5, "timeout");
      exp_q.delete();
      never_ack = 1'b0;
      ahb_single(32'h304, 3'd2, 1'b0, 32'h0, 1'b1, 1'b0, 0, "post_to");
`endif

      // Asynchronous reset in the middle of a hung strobe
      never_ack = 1'b1;
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HADDR  = 32'h400;
      HWRITE = 1'b1;
      HSIZE  = 3'd2;
      @(posedge HCLK);
      #1;
      drive_idle();
      HWDATA = 32'h0BAD_F00D;
      @(posedge HCLK);
      @(posedge HCLK);
      #3;
      check("prerst_cyc", wb_cyc_o, 1);
      HRESET = 1'b1;
      #1;
      check("arst_cyc",  wb_cyc_o, 0);
      check("arst_stb",  wb_stb_o, 0);
      check("arst_resp", HRESP, 0);
      check("arst_rdy",  HREADYOUT, 1);
      exp_q.delete();
      never_ack = 1'b0;
      @(negedge HCLK);
      HRESET = 1'b0;
      @(posedge HCLK);
      #1;
      ahb_single(32'h404, 3'd2, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 0, "post_rst");

      // Random legal transfers with random ack latency
      for (int i = 0; i < 8; i++) begin
         logic [31:0] a;
         logic [2:0]  sz;
         logic        w;
         sz        = 3'($urandom_range(0, 2));
         a         = 32'h800 + 32'($urandom_range(0, 63));
         a         = a & ~((32'd1 << sz) - 32'd1);
         w         = 1'($urandom_range(0, 1));
         ack_delay = $urandom_range(0, 3);
         ahb_single(a, sz, w, $urandom, 1'b1, 1'b0, ack_delay, "rnd");
      end

      repeat (2) @(posedge HCLK);
      check("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
